// File: rtl/wisc_isa_pkg.sv
// Shared ISA encodings for the ALU flag / branch interface: opcodes, condition
// codes, flag bit positions and the per-opcode flag write mask.
package wisc_isa_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam logic [2:0] CCC_NE = 3'b000;
  localparam logic [2:0] CCC_EQ = 3'b001;
  localparam logic [2:0] CCC_GT = 3'b010;
  localparam logic [2:0] CCC_LT = 3'b011;
  localparam logic [2:0] CCC_GE = 3'b100;
  localparam logic [2:0] CCC_LE = 3'b101;
  localparam logic [2:0] CCC_OV = 3'b110;
  localparam logic [2:0] CCC_UN = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} br_state_t;

  // Which flag bits an opcode updates; unmasked bits keep their old value.
  function automatic logic [2:0] flag_wmask(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB:                 flag_wmask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_wmask = 3'b001;
      default:                        flag_wmask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation: condition code against {V,N,Z}.
module branch_cond
  import wisc_isa_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       take
);

  logic z, n, v;

  assign z = flags[FLG_Z];
  assign n = flags[FLG_N];
  assign v = flags[FLG_V];

  always_comb begin
    take = 1'b0;
    case (ccc)
      CCC_NE:  take = ~z;
      CCC_EQ:  take = z;
      CCC_GT:  take = ~z & ~n;
      CCC_LT:  take = n;
      CCC_GE:  take = z | ~n;
      CCC_LE:  take = z | n;
      CCC_OV:  take = v;
      default: take = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register plus ID-stage branch resolution with a one-cycle
// stall when the branch and a flag-writing EX instruction coincide.
//
//   state | meaning
//   IDLE  | accepting branches; resolves immediately unless flags are being written
//   HOLD  | waiting one cycle for the in-flight flag write to land, then resolves
module flag_branch_unit
  import wisc_isa_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        alu_flags,
  input  logic [2:0]        alu_op,
  input  logic              flag_we,
  input  logic              stall_ex,
  input  logic              flush_in,
  input  logic              br_valid,
  input  logic              br_reg,
  input  logic [2:0]        br_ccc,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [ADDR_W-1:0] pc_plus2,
  input  logic [ADDR_W-1:0] br_rs_data,
  output logic [2:0]        flags_q,
  output logic              br_stall,
  output logic              br_done,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target
);

  br_state_t         state;
  logic [2:0]        wmask;
  logic              flag_write;
  logic              take;
  logic              accept;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target_calc;

  assign wmask      = flag_wmask(alu_op) & {3{flag_we & ~stall_ex}};
  assign flag_write = |wmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 3'b000;
    else        flags_q <= (flags_q & ~wmask) | (alu_flags & wmask);
  end

  branch_cond u_cond (
    .ccc   (br_ccc),
    .flags (flags_q),
    .take  (take)
  );

  // Offset is in words, so sign-extend then scale to bytes; wraps mod 2^ADDR_W.
  assign offset      = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm} << 1;
  assign target_calc = br_reg ? br_rs_data : pc_plus2 + offset;

  assign accept   = (state == ST_IDLE) & br_valid & ~flush_in;
  assign br_stall = accept & flag_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      case (state)
        ST_IDLE: begin
          if (accept && flag_write) begin
            state <= ST_HOLD;
          end else if (accept) begin
            br_done   <= 1'b1;
            br_taken  <= take;
            br_target <= take ? target_calc : '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          if (!flush_in) begin
            br_done   <= 1'b1;
            br_taken  <= take;
            br_target <= take ? target_calc : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag write rules, branch latency,
// hazard stall, flush in HOLD, async reset and a full condition sweep.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alu_flags;
  logic [2:0]  alu_op;
  logic        flag_we;
  logic        stall_ex;
  logic        flush_in;
  logic        br_valid;
  logic        br_reg;
  logic [2:0]  br_ccc;
  logic [8:0]  br_imm;
  logic [15:0] pc_plus2;
  logic [15:0] br_rs_data;
  logic [2:0]  flags_q;
  logic        br_stall;
  logic        br_done;
  logic        br_taken;
  logic [15:0] br_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_flags(alu_flags), .alu_op(alu_op),
    .flag_we(flag_we), .stall_ex(stall_ex), .flush_in(flush_in),
    .br_valid(br_valid), .br_reg(br_reg), .br_ccc(br_ccc), .br_imm(br_imm),
    .pc_plus2(pc_plus2), .br_rs_data(br_rs_data), .flags_q(flags_q),
    .br_stall(br_stall), .br_done(br_done), .br_taken(br_taken),
    .br_target(br_target)
  );

  // Reference condition table, flags = {V,N,Z}.
  function automatic logic exp_take(input logic [2:0] c, input logic [2:0] f);
    logic z, n, v;
    z = f[0]; n = f[1]; v = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    alu_op = 3'b000; alu_flags = f; flag_we = 1'b1;
    step();
    flag_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alu_flags = 0; alu_op = 0; flag_we = 0; stall_ex = 0;
    flush_in = 0; br_valid = 0; br_reg = 0; br_ccc = 0; br_imm = 0;
    pc_plus2 = 0; br_rs_data = 0;
    #3;
    chk("rst_flags", {13'd0, flags_q}, 16'h0);
    chk("rst_done", {15'd0, br_done}, 16'h0);
    chk("rst_stall", {15'd0, br_stall}, 16'h0);
    chk("rst_target", br_target, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ADD writes all flags, XOR writes Z only
    alu_op = 3'b000; alu_flags = 3'b111; flag_we = 1'b1;
    step();
    chk("add_flags", {13'd0, flags_q}, 16'h0007);
    alu_op = 3'b010; alu_flags = 3'b000;
    step();
    chk("xor_flags", {13'd0, flags_q}, 16'h0006);
    flag_we = 1'b0;

    // 2: B EQ, no hazard, latency 1, negative offset
    set_flags(3'b001);
    br_valid = 1; br_reg = 0; br_ccc = 3'b001; br_imm = 9'h1FE; pc_plus2 = 16'h0010;
    #1;
    chk("b_eq_nostall", {15'd0, br_stall}, 16'h0);
    step();
    chk("b_eq_done", {15'd0, br_done}, 16'h1);
    chk("b_eq_taken", {15'd0, br_taken}, 16'h1);
    chk("b_eq_target", br_target, 16'h000C);
    br_valid = 0;
    step();
    chk("b_eq_pulse", {15'd0, br_done}, 16'h0);

    // 3: hazard, SUB sets Z while B NE waits; stale flags would say taken
    set_flags(3'b000);
    alu_op = 3'b001; alu_flags = 3'b001; flag_we = 1;
    br_valid = 1; br_ccc = 3'b000; br_imm = 9'h004; pc_plus2 = 16'h0020;
    #1;
    chk("haz_stall", {15'd0, br_stall}, 16'h1);
    step();
    flag_we = 0;
    #1;
    chk("haz_hold_nostall", {15'd0, br_stall}, 16'h0);
    chk("haz_hold_nodone", {15'd0, br_done}, 16'h0);
    step();
    br_valid = 0;
    chk("haz_done", {15'd0, br_done}, 16'h1);
    chk("haz_taken", {15'd0, br_taken}, 16'h0);
    chk("haz_target", br_target, 16'h0);

    // 4: flush in HOLD abandons; FSM must be IDLE again (stall seen on next hazard)
    alu_op = 3'b000; alu_flags = 3'b000; flag_we = 1;
    br_valid = 1; br_ccc = 3'b001;
    #1;
    chk("fl_stall", {15'd0, br_stall}, 16'h1);
    step();
    flag_we = 0; flush_in = 1;
    step();
    chk("fl_nodone", {15'd0, br_done}, 16'h0);
    flush_in = 0;
    alu_op = 3'b000; alu_flags = 3'b010; flag_we = 1;
    br_ccc = 3'b100;
    #1;
    chk("fl_idle_stall", {15'd0, br_stall}, 16'h1);
    step();
    flag_we = 0;
    step();
    chk("fl_next_done", {15'd0, br_done}, 16'h1);
    chk("fl_next_taken", {15'd0, br_taken}, 16'h0);
    br_ccc = 3'b011; br_imm = 9'h003; pc_plus2 = 16'h0100;
    step();
    chk("b_lt_done", {15'd0, br_done}, 16'h1);
    chk("b_lt_target", br_target, 16'h0106);
    br_valid = 0;

    // 5: BR UN; non-writing ops and stall_ex leave flags alone; SLL writes Z only
    br_valid = 1; br_reg = 1; br_ccc = 3'b111; br_rs_data = 16'hBEEF;
    step();
    br_valid = 0; br_reg = 0;
    chk("br_un_taken", {15'd0, br_taken}, 16'h1);
    chk("br_un_target", br_target, 16'hBEEF);
    alu_flags = 3'b111; flag_we = 1; alu_op = 3'b011;
    step();
    chk("red_flags", {13'd0, flags_q}, 16'h0002);
    alu_op = 3'b111;
    step();
    chk("paddsb_flags", {13'd0, flags_q}, 16'h0002);
    alu_op = 3'b000; stall_ex = 1;
    step();
    chk("stall_ex_flags", {13'd0, flags_q}, 16'h0002);
    stall_ex = 0; alu_op = 3'b100; alu_flags = 3'b101;
    step();
    chk("sll_flags", {13'd0, flags_q}, 16'h0003);
    flag_we = 0;

    // 6: async reset mid-HOLD
    alu_op = 3'b000; alu_flags = 3'b110; flag_we = 1; br_valid = 1; br_ccc = 3'b111;
    step();
    flag_we = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_flags", {13'd0, flags_q}, 16'h0);
    chk("arst_done", {15'd0, br_done}, 16'h0);
    chk("arst_stall", {15'd0, br_stall}, 16'h0);
    br_valid = 0;
    @(negedge clk);
    rst_n = 1;

    // Sweep every ccc against every flag value; valid held, so done runs back-to-back
    for (int f = 0; f < 8; f++) begin
      set_flags(f[2:0]);
      chk("sweep_flags", {13'd0, flags_q}, {13'd0, f[2:0]});
      br_valid = 1; br_reg = 1; br_rs_data = 16'h1234 + 16'(f);
      for (int c = 0; c < 8; c++) begin
        br_ccc = c[2:0];
        step();
        chk("sweep_done", {15'd0, br_done}, 16'h1);
        chk("sweep_taken", {15'd0, br_taken}, {15'd0, exp_take(c[2:0], f[2:0])});
        chk("sweep_target", br_target,
            exp_take(c[2:0], f[2:0]) ? 16'h1234 + 16'(f) : 16'h0);
      end
      br_valid = 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
